// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus width, NOP encoding,
// pipeline hold encodings, fetch FSM states and the buffered FIFO entry layout.
package if_fetch_pkg;

    localparam int BUS_W = 32;

    localparam logic [BUS_W-1:0] INST_NOP = 32'h0000_0001;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } fetch_state_t;

    // One buffered instruction: bus error flag, fetch address and returned word.
    typedef struct packed {
        logic             err;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] data;
    } fetch_entry_t;

    function automatic logic [BUS_W-1:0] next_pc(input logic [BUS_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with async reset, synchronous clear, occupancy count
// and a combinational head. DEPTH must be a power of two so pointers wrap freely.
module if_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, keeps up to DEPTH word fetches in flight
// and buffers returned instructions for IF/ID. Define IF_FETCH_BUS_ERR_EN for bus error tagging.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [BUS_W-1:0]  jump_addr_i,
    input  logic [2:0]        hold_flag_i,
    output logic              ibus_req_o,
    output logic [BUS_W-1:0]  ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [BUS_W-1:0]  ibus_rdata_i,
`ifdef IF_FETCH_BUS_ERR_EN
    input  logic              ibus_err_i,
    output logic              inst_fault_o,
`endif
    output logic              inst_valid_o,
    output logic [BUS_W-1:0]  inst_o,
    output logic [BUS_W-1:0]  inst_addr_o
);

    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(DEPTH);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [BUS_W-1:0] pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] discard_nxt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             grant;
    logic             resp_drop;
    logic             resp_push;
    logic             resp_err;
    logic             pop_en;

    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             data_empty;
    logic             data_full;

    logic [BUS_W-1:0] addr_head;
    logic             addr_empty;
    logic             addr_full;
    logic [CNT_W-1:0] addr_count;

`ifdef IF_FETCH_BUS_ERR_EN
    assign resp_err = ibus_err_i;
`else
    assign resp_err = 1'b0;
`endif

    // Buffered words plus words still in flight must never exceed the FIFO size.
    assign occupancy  = {1'b0, fifo_count} + {1'b0, outstanding};
    assign ibus_req_o = (state != ST_IDLE) && (hold_flag_i != HOLD_PC) && (occupancy < DEPTH_L);
    assign ibus_addr_o = pc;
    assign grant       = ibus_req_o && ibus_gnt_i;

    assign resp_drop = ibus_rvalid_i && (discard != '0);
    assign resp_push = ibus_rvalid_i && (discard == '0) && !jump_flag_i;
    assign pop_en    = (hold_flag_i < HOLD_IF);

    assign outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(ibus_rvalid_i);

    assign push_entry = '{err: resp_err, addr: addr_head, data: ibus_rdata_i};

    // Request addresses in grant order; every response consumes one, dropped or not.
    if_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (grant),
        .push_data (pc),
        .pop       (ibus_rvalid_i),
        .head      (addr_head),
        .empty     (addr_empty),
        .full      (addr_full),
        .count     (addr_count)
    );

    if_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (jump_flag_i),
        .push      (resp_push),
        .push_data (push_entry),
        .pop       (pop_en),
        .head      (head_entry),
        .empty     (data_empty),
        .full      (data_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A jump overrides everything: all responses still in flight after this cycle get dropped.
    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        case (state)
            ST_IDLE:  state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            ST_FLUSH: begin
                if (resp_drop && (discard == CNT_W'(1))) begin
                    state_nxt = ST_RUN;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
        if (resp_drop) begin
            discard_nxt = discard - CNT_W'(1);
        end
        if (jump_flag_i) begin
            discard_nxt = outstanding_nxt;
            state_nxt   = (outstanding_nxt != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            if (jump_flag_i) begin
                pc <= jump_addr_i;
            end else if (grant) begin
                pc <= next_pc(pc);
            end
        end
    end

    assign inst_valid_o = !data_empty;
    assign inst_o       = (data_empty || head_entry.err) ? INST_NOP : head_entry.data;
    assign inst_addr_o  = data_empty ? '0 : head_entry.addr;

`ifdef IF_FETCH_BUS_ERR_EN
    assign inst_fault_o = !data_empty && head_entry.err;
`endif

    // Bus protocol violations and internal bookkeeping invariants.
    a_rvalid_without_request: assert property (@(posedge clk) disable iff (rst)
        !(ibus_rvalid_i && (outstanding == '0)));
    a_addr_fifo_nonempty: assert property (@(posedge clk) disable iff (rst)
        !(ibus_rvalid_i && addr_empty));
    a_addr_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(grant && addr_full));
    a_addr_count_tracks: assert property (@(posedge clk) disable iff (rst)
        (addr_count == outstanding));
    a_data_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(resp_push && data_full && !pop_en));

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a bus model feeds responses, an expected-instruction
// queue is filled as responses are driven and compared against the IF/ID outputs.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [2:0]  hold_flag;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
`ifdef IF_FETCH_BUS_ERR_EN
    logic        ibus_err;
    logic        inst_fault;
`endif

    if_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag),
        .jump_addr_i   (jump_addr),
        .hold_flag_i   (hold_flag),
        .ibus_req_o    (ibus_req),
        .ibus_addr_o   (ibus_addr),
        .ibus_gnt_i    (ibus_gnt),
        .ibus_rvalid_i (ibus_rvalid),
        .ibus_rdata_i  (ibus_rdata),
`ifdef IF_FETCH_BUS_ERR_EN
        .ibus_err_i    (ibus_err),
        .inst_fault_o  (inst_fault),
`endif
        .inst_valid_o  (inst_valid),
        .inst_o        (inst),
        .inst_addr_o   (inst_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] resp_q[$];
    logic [31:0] pc_m;
    int          outst_m;
    int          discard_m;
    bit          run_m;
    int          checks;
    int          errors;
    int          rv_count;
    bit          seen_valid;
    logic [31:0] seen_addr;
    logic        last_valid;
    logic        last_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One bus cycle: drive inputs, check outputs at negedge, advance the model.
    task automatic applyStimulus(input bit jump, input logic [31:0] jaddr, input logic [2:0] hold,
                                 input bit gnt, input bit rv, input bit err);
        bit          rv_m;
        bit          req_m;
        bit          grant_m;
        bit          pop_m;
        bit          err_m;
        logic [31:0] rsp_addr;
        exp_t        e;
        rv_m  = rv && (resp_q.size() > 0);
        err_m = 1'b0;
`ifdef IF_FETCH_BUS_ERR_EN
        err_m = rv_m && err;
        ibus_err = err_m;
`else
        err_m = err && 1'b0;
`endif
        jump_flag   = jump;
        jump_addr   = jaddr;
        hold_flag   = hold;
        ibus_gnt    = gnt;
        ibus_rvalid = rv_m;
        ibus_rdata  = rv_m ? mem_word(resp_q[0]) : 32'hDEAD_BEEF;

        @(negedge clk);
        req_m = run_m && (hold != HOLD_PC) && ((exp_q.size() + outst_m) < DEPTH);
        checkOutput("ibus_req", {31'b0, ibus_req}, {31'b0, req_m});
        checkOutput("ibus_addr", ibus_addr, pc_m);
        if (exp_q.size() > 0) begin
            checkOutput("inst_valid", {31'b0, inst_valid}, 32'd1);
            checkOutput("inst_addr", inst_addr, exp_q[0].addr);
            checkOutput("inst", inst, exp_q[0].err ? INST_NOP : exp_q[0].data);
`ifdef IF_FETCH_BUS_ERR_EN
            checkOutput("inst_fault", {31'b0, inst_fault}, {31'b0, exp_q[0].err});
`endif
        end else begin
            checkOutput("inst_valid_idle", {31'b0, inst_valid}, 32'd0);
            checkOutput("inst_idle", inst, INST_NOP);
            checkOutput("inst_addr_idle", inst_addr, 32'd0);
        end
        last_valid = inst_valid;
        last_req   = ibus_req;
        if (inst_valid && !seen_valid) begin
            seen_valid = 1'b1;
            seen_addr  = inst_addr;
        end

        grant_m  = req_m && gnt;
        pop_m    = (exp_q.size() > 0) && (hold < HOLD_IF);
        rsp_addr = 32'h0;
        if (rv_m) begin
            rsp_addr = resp_q.pop_front();
            rv_count++;
        end
        if (grant_m) resp_q.push_back(pc_m);
        if (jump) begin
            exp_q.delete();
            discard_m = outst_m + int'(grant_m) - int'(rv_m);
            pc_m      = jaddr;
        end else begin
            if (pop_m) e = exp_q.pop_front();
            if (rv_m) begin
                if (discard_m > 0) discard_m--;
                else exp_q.push_back('{addr: rsp_addr, data: mem_word(rsp_addr), err: err_m});
            end
            if (grant_m) pc_m = pc_m + 32'd4;
        end
        outst_m = outst_m + int'(grant_m) - int'(rv_m);

        @(posedge clk);
        #1;
        run_m = 1'b1;
    endtask

    task automatic drainBus();
        for (int i = 0; i < 20 && (outst_m > 0 || exp_q.size() > 0); i++) begin
            applyStimulus(1'b0, 32'h0, HOLD_NONE, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drain_done", (outst_m > 0 || exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; rv_count = 0;
        outst_m = 0; discard_m = 0; run_m = 1'b0; pc_m = RESET_PC;
        seen_valid = 1'b0; seen_addr = 32'hFFFF_FFFF;
        rst = 1'b1; jump_flag = 1'b0; jump_addr = '0; hold_flag = HOLD_NONE;
        ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
`ifdef IF_FETCH_BUS_ERR_EN
        ibus_err = 1'b0;
`endif
        #12;
        checkOutput("rst_req", {31'b0, ibus_req}, 32'd0);
        checkOutput("rst_addr", ibus_addr, RESET_PC);
        checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rst_inst", inst, 32'h0000_0001);
        checkOutput("rst_inst_addr", inst_addr, 32'd0);
`ifdef IF_FETCH_BUS_ERR_EN
        checkOutput("rst_fault", {31'b0, inst_fault}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming fetch with grant every cycle and one-cycle response latency.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 32'h0, HOLD_NONE, 1'b1, 1'b1, 1'b0);
            if (i == 2) checkOutput("valid_cycle2", {31'b0, last_valid}, 32'd0);
            if (i == 3) checkOutput("valid_cycle3", {31'b0, last_valid}, 32'd1);
        end

        // Hold IF: FIFO fills, requests stop, head frozen; then release.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, HOLD_IF, 1'b1, 1'b1, 1'b0);
        checkOutput("hold_req_dropped", {31'b0, last_req}, 32'd0);
        checkOutput("hold_fifo_full", {31'b0, last_valid}, 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, HOLD_NONE, 1'b1, 1'b1, 1'b0);

        // Jump with two requests outstanding.
        for (int i = 0; i < 10 && !(outst_m == 2 && exp_q.size() == 0); i++)
            applyStimulus(1'b0, 32'h0, HOLD_NONE, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0100, HOLD_NONE, 1'b1, 1'b0, 1'b0);
        seen_valid = 1'b0; seen_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 20 && !seen_valid; i++)
            applyStimulus(1'b0, 32'h0, HOLD_NONE, 1'b1, 1'b1, 1'b0);
        checkOutput("jump_first_addr", seen_addr, 32'h0000_0100);

        // Jump coinciding with a grant and a response.
        drainBus();
        applyStimulus(1'b0, 32'h0, HOLD_NONE, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0200, HOLD_NONE, 1'b1, 1'b1, 1'b0);
        seen_valid = 1'b0; seen_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 20 && !seen_valid; i++)
            applyStimulus(1'b0, 32'h0, HOLD_NONE, 1'b1, 1'b1, 1'b0);
        checkOutput("jump_gnt_rv_first_addr", seen_addr, 32'h0000_0200);

        // PC wrap at the top of the address space.
        drainBus();
        applyStimulus(1'b1, 32'hFFFF_FFFC, HOLD_NONE, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, HOLD_NONE, 1'b1, 1'b0, 1'b0);
        checkOutput("pc_wrap", ibus_addr, 32'h0000_0000);
        drainBus();

`ifdef IF_FETCH_BUS_ERR_EN
        // Error flagged on the second response only.
        rv_count = 0;
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 32'h0, HOLD_NONE, 1'b1, 1'b1, rv_count == 1);
        drainBus();
`endif

        // Randomised traffic with holds, stalls and occasional jumps.
        for (int i = 0; i < 250; i++) begin
            applyStimulus(($urandom % 16) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
                          3'($urandom_range(0, 3)), ($urandom % 4) != 0,
                          ($urandom % 3) != 0, ($urandom % 5) == 0);
        end

        // Asynchronous reset in the middle of traffic.
        rst = 1'b1;
        ibus_rvalid = 1'b0;
        ibus_gnt = 1'b0;
        #2;
        checkOutput("midrst_req", {31'b0, ibus_req}, 32'd0);
        checkOutput("midrst_addr", ibus_addr, RESET_PC);
        checkOutput("midrst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("midrst_inst", inst, INST_NOP);
        checkOutput("midrst_inst_addr", inst_addr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit for the core front end. It owns the PC, issues in-order word fetches on the instruction bus with up to `DEPTH` requests outstanding, and buffers returned words with their addresses in a small FIFO. It presents one instruction per cycle to the IF/ID pipeline register directly downstream, and handles redirects (jumps) and pipeline holds.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `DEPTH`, 2, FIFO entries; also the outstanding-request limit; power of two, ≥2
- `clk`  in  1  core clock
- `rst`  in  1  reset; asynchronous, active-high
- `jump_flag_i`  in  1  redirect request from execute
- `jump_addr_i`  in  32  redirect target; word aligned
- `hold_flag_i`  in  3  pipeline hold: 0 none, 1 hold PC, 2 hold IF, 3 hold ID
- `ibus_req_o`  out  1  fetch request
- `ibus_addr_o`  out  32  fetch address; equals PC
- `ibus_gnt_i`  in  1  request accepted this cycle
- `ibus_rvalid_i`  in  1  read data valid; responses return in order
- `ibus_rdata_i`  in  32  instruction word
- `inst_valid_o`  out  1  `inst_o` holds a real instruction
- `inst_o`  out  32  instruction to IF/ID; `INST_NOP` when not valid
- `inst_addr_o`  out  32  address of `inst_o`; 0 when not valid

## Operation
- State machine with three states:
  - IDLE: reset state; moves to RUN on the first cycle after reset.
  - RUN: normal fetch.
  - FLUSH: entered on a jump while `discard` is nonzero; returns to RUN when `discard` reaches 0.
- Counters:
  - `outstanding` counts granted requests not yet returned.
  - `discard` counts in-flight responses to drop.
- Request rule:
  - `ibus_req_o` = 1 in RUN or FLUSH when `hold_flag_i` is not 1 and `fifo_count + outstanding < DEPTH`.
  - Request is issued in FLUSH too, because new requests follow the discarded ones.
- On grant (`ibus_req_o & ibus_gnt_i`): PC <= PC + 4, with 32-bit wrap; `outstanding` increments.
- On `ibus_rvalid_i`:
  - `outstanding` decrements.
  - If `discard` > 0, the data is dropped and `discard` decrements.
  - Otherwise `{PC-of-request, rdata}` is pushed to the FIFO. The request address comes from a parallel address FIFO written at grant.
- Pop rule: pop when `hold_flag_i < 3'b010` and the FIFO is non-empty. The FIFO head drives `inst_o`/`inst_addr_o` combinationally, with `inst_valid_o` = !empty.
- Jump (`jump_flag_i` = 1) takes priority over all other events in that cycle:
  - PC <= `jump_addr_i`; FIFO cleared.
  - `discard` <= `outstanding` − (rvalid this cycle) + (grant this cycle).
  - State goes to FLUSH if that value is > 0, else RUN.
- Outputs when `inst_valid_o` = 0: `inst_o` = `INST_NOP` (32'h00000001), `inst_addr_o` = 0.

## Timing
- Reset values:
  - `ibus_req_o` 0, `ibus_addr_o` `RESET_PC`.
  - `inst_valid_o` 0, `inst_o` 32'h00000001, `inst_addr_o` 0.
  - Counters 0, state IDLE.
- First `ibus_req_o` appears in cycle 1 after reset deassertion.
- Latency: response in cycle N is written at the end of N and visible on `inst_o` in N+1. There is no bypass.
- Push and pop in the same cycle are both performed; `fifo_count` is unchanged.
- The FIFO never overflows by construction. Push while full, or rvalid with `outstanding` = 0, are protocol errors; they have no defined behaviour and are flagged by assertions.
- `hold_flag_i` = 1 blocks new requests only. Responses still land in the FIFO.
- Reset asserted mid-operation clears everything asynchronously. Bus responses to pre-reset requests are the bus's responsibility.

## Configuration
- `IF_FETCH_BUS_ERR_EN` defined:
  - Adds input `ibus_err_i` (1, qualifies `ibus_rvalid_i`) and output `inst_fault_o` (1).
  - The error bit is stored per FIFO entry. An erroneous entry outputs `inst_o` = `INST_NOP` with `inst_valid_o` = 1 and `inst_fault_o` = 1.
  - `inst_fault_o` resets to 0.
- Undefined: neither port exists, and all responses are treated as good.

## Structure
- Shared core package holds:
  - `INST_NOP` = 32'h00000001.
  - Hold encodings `HOLD_NONE`/`HOLD_PC`/`HOLD_IF`/`HOLD_ID` = 0..3.
  - Bus width constant 32.
- One sub-module, `if_fifo`: parameterised width/depth synchronous FIFO with async reset, a clear input, `count` output and combinational head. Instantiate once for data + error bit and once for request addresses.

## Test plan
- Reset release, bus grants every cycle, rvalid one cycle after grant → `ibus_addr_o` sequence 0,4,8,…; `inst_o` valid from cycle 3 with matching `inst_addr_o`.
- `hold_flag_i` = 2 held 5 cycles with fetches pending → FIFO fills to 2; `ibus_req_o` drops; `inst_o` frozen; one pop per cycle resumes after release.
- Jump to 32'h100 with 2 outstanding → both responses dropped; next `inst_valid_o` shows `inst_addr_o` = 32'h100.
- Jump in the same cycle as grant and rvalid → `discard` = `outstanding`; no stale instruction reaches `inst_o`.
- PC 32'hFFFFFFFC granted → next `ibus_addr_o` = 0.
- With `IF_FETCH_BUS_ERR_EN`, `ibus_err_i` on 2nd response → that slot shows `inst_o` = 32'h00000001, `inst_fault_o` = 1; neighbours unaffected.
